// File: rtl/lut_loader_pkg.sv
// Shared types and default constants for the serial LUT table loader.
package lut_loader_pkg;

  localparam int LUT_TABLE_BITS = 64;
  localparam int LUT_HALF_PER   = 2;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    LO,
    HI,
    STALL,
    FINISH
  } state_t;

endpackage

// File: rtl/lut_sclk_timer.sv
// Reloadable half-period down-counter; expire is high on the last cycle of a
// half-period that was started by load.
module lut_sclk_timer
  import lut_loader_pkg::*;
#(
  parameter int HALF_PER = LUT_HALF_PER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(HALF_PER + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(HALF_PER - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/lut_table_loader.sv
// Byte-stream to three-wire serial loader for the 16x4 LUT, MSB first.
// Optional nibble checksum output enabled by defining LUT_LOADER_CKSUM_EN.
module lut_table_loader
  import lut_loader_pkg::*;
#(
  parameter int TABLE_BITS = LUT_TABLE_BITS,
  parameter int HALF_PER   = LUT_HALF_PER
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sd,
  output logic       sclk,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic       aborted
`ifdef LUT_LOADER_CKSUM_EN
  ,
  output logic [3:0] cksum
`endif
);

  localparam int NBYTES = TABLE_BITS / 8;
  localparam int BCW    = $clog2(TABLE_BITS + 1);
  localparam int YCW    = $clog2(NBYTES + 1);
  localparam logic [BCW-1:0] BITS_L  = BCW'(TABLE_BITS);
  localparam logic [YCW-1:0] BYTES_L = YCW'(NBYTES);

  state_t         state, state_d;
  logic           expire, tmr_load;
  logic [7:0]     shreg, shreg_d, hold, hold_d;
  logic           full, full_d;
  logic [BCW-1:0] bit_cnt, bit_cnt_d, bit_inc;
  logic [YCW-1:0] byte_cnt, byte_cnt_d;
  logic           aborted_d, sd_d, sclk_d, cs_n_d, busy_d, done_d, in_ready_d;
  logic           accept, hi_exit, boundary, last_bit, move_hold;

  assign accept   = in_valid & in_ready;
  assign hi_exit  = (state == HI) && expire;
  assign bit_inc  = bit_cnt + 1'b1;
  assign boundary = (bit_inc[2:0] == 3'd0);
  assign last_bit = (bit_inc == BITS_L);

  // Every state change restarts the half-period; only LO, HI and FINISH use it.
  assign tmr_load = (state_d != state);

  lut_sclk_timer #(.HALF_PER(HALF_PER)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (start) state_d = PREP;
      PREP:   if (accept) state_d = LO;
      LO:     if (expire) state_d = HI;
      HI: begin
        if (expire) begin
          if (last_bit)                state_d = FINISH;
          else if (boundary && !full)  state_d = STALL;
          else                         state_d = LO;
        end
      end
      STALL:  if (full) state_d = LO;
      FINISH: if (expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state != IDLE && abort) state_d = IDLE;
  end

  // Outputs are decoded from the next state and registered below, so the
  // serial pins switch cleanly on the clock edge.
  always_comb begin
    sclk_d = (state_d == HI);
    cs_n_d = !(state_d inside {LO, HI, STALL, FINISH});
    busy_d = (state_d != IDLE);
    done_d = (state == FINISH) && expire && !abort;
  end

  assign move_hold = (state_d == LO) && ((state == STALL) || (state == HI && boundary));

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hold_d     = hold;
    full_d     = full;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    aborted_d  = aborted;
    if (state == IDLE) begin
      if (start) begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        aborted_d  = 1'b0;
        full_d     = 1'b0;
      end
    end else if (abort) begin
      full_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      if (accept) begin
        byte_cnt_d = byte_cnt + 1'b1;
        // The first byte bypasses the holding register so PREP lasts one cycle.
        if (state == PREP) begin
          shreg_d = in_data;
        end else begin
          hold_d = in_data;
          full_d = 1'b1;
        end
      end
      if (hi_exit) begin
        bit_cnt_d = bit_inc;
        if (!boundary) shreg_d = {shreg[6:0], 1'b0};
      end
      if (move_hold) begin
        shreg_d = hold;
        full_d  = 1'b0;
      end
    end
    sd_d       = ((state_d == LO) && (state != LO)) ? shreg_d[7] : sd;
    in_ready_d = busy_d && !full_d && (byte_cnt_d < BYTES_L);
  end

  // NOTE: the holding byte and shift register are datapath that could go
  // unreset; they are reset here so sd comes up at a defined level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      full     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      aborted  <= 1'b0;
      sd       <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      hold     <= hold_d;
      full     <= full_d;
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      byte_cnt <= byte_cnt_d;
      aborted  <= aborted_d;
      sd       <= sd_d;
      sclk     <= sclk_d;
      cs_n     <= cs_n_d;
      busy     <= busy_d;
      done     <= done_d;
      in_ready <= in_ready_d;
    end
  end

`ifdef LUT_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum <= '0;
    end else if (state == IDLE && start) begin
      cksum <= '0;
    end else if (state != IDLE && !abort && accept) begin
      cksum <= cksum ^ in_data[7:4] ^ in_data[3:0];
    end
  end
`endif

endmodule

// File: tb/tb_lut_table_loader.sv
// Bench for lut_table_loader: a LUT shift model plus a serial-bit scoreboard,
// table-driven full loads and hand-written abort/reset sequences.
module tb_lut_table_loader;
  import lut_loader_pkg::*;

  localparam int HP       = LUT_HALF_PER;
  localparam int TB       = LUT_TABLE_BITS;
  localparam int LOAD_LAT = 1 + 2 * HP * TB + HP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, sd, sclk, cs_n, busy, done, aborted;
`ifdef LUT_LOADER_CKSUM_EN
  logic [3:0] cksum;
`endif

  lut_table_loader #(.TABLE_BITS(TB), .HALF_PER(HP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sd       (sd),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
`ifdef LUT_LOADER_CKSUM_EN
    ,
    .cksum    (cksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          stall_len;
    bit          start_mid;
    logic [63:0] exp_lut;
    logic [3:0]  exp_ck;
  } vec_t;

  vec_t vecs[4];

  int n_vec = 0;
  int n_bad = 0;
  bit exp_q[$];
  logic [TB-1:0] lut_model = '0;
  int edge_cnt = 0, framing_err = 0, low_run = 0, max_low = 0, extra_acc = 0;
  logic sclk_q = 1'b0, sd_q = 1'b0, cs_n_q = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LUT side: capture on sclk rise with cs_n low, sampled between clk edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      sclk_q = 1'b0; sd_q = 1'b0; cs_n_q = 1'b1; low_run = 0;
    end else begin
      if (sclk && !sclk_q && !cs_n) begin
        edge_cnt++;
        lut_model = {lut_model[TB-2:0], sd};
        check("sd_queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sd_bit", sd, exp_q.pop_front());
      end
      if (sclk && (sd !== sd_q || cs_n !== cs_n_q)) framing_err++;
      if (!cs_n && !sclk) low_run++;
      else low_run = 0;
      if (low_run > max_low) max_low = low_run;
      sclk_q = sclk; sd_q = sd; cs_n_q = cs_n;
    end
  end

  // One negedge of the byte source; hold_off withholds bytes after byte 3.
  task automatic drive_step(input logic [63:0] data, inout int b, inout int hold_off,
                            input int stall_len);
    if (b < 8 && hold_off == 0) begin
      in_valid = 1'b1;
      in_data  = data[63-8*b -: 8];
      if (in_ready) begin
        for (int k = 7; k >= 0; k--) exp_q.push_back(in_data[k]);
        b++;
        if (b == 4) hold_off = stall_len;
      end
    end else begin
      if (hold_off > 0) hold_off--;
      in_valid = (b >= 8);
      in_data  = 8'hEE;
      if (b >= 8 && in_ready) extra_acc++;
    end
  endtask

  task automatic do_load(input vec_t v, input int idx);
    int  b = 0, hold_off = 0, cyc = 0;
    bit  got = 1'b0;
    exp_q.delete();
    edge_cnt = 0; framing_err = 0; max_low = 0; low_run = 0; extra_acc = 0;
    lut_model = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check($sformatf("v%0d_busy_rise", idx), busy, 1);
    check($sformatf("v%0d_aborted_clr", idx), aborted, 0);
    while (cyc < 4000) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (v.start_mid && cyc == 100);
      drive_step(v.data, b, hold_off, v.stall_len);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    check($sformatf("v%0d_done_seen", idx), got, 1);
    if (v.stall_len == 0) begin
      check($sformatf("v%0d_latency", idx), cyc, LOAD_LAT);
      check($sformatf("v%0d_low_run", idx), max_low, HP);
    end else begin
      check($sformatf("v%0d_stall_low_run", idx), max_low >= 20, 1);
    end
    check($sformatf("v%0d_done_busy", idx), {busy, cs_n, sclk}, 3'b010);
    check($sformatf("v%0d_edges", idx), edge_cnt, TB);
    check($sformatf("v%0d_lut", idx), lut_model, v.exp_lut);
    check($sformatf("v%0d_q_empty", idx), exp_q.size(), 0);
    check($sformatf("v%0d_framing", idx), framing_err, 0);
    check($sformatf("v%0d_extra_accept", idx), extra_acc, 0);
`ifdef LUT_LOADER_CKSUM_EN
    check($sformatf("v%0d_cksum", idx), cksum, v.exp_ck);
`endif
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b, hold_off, cyc, n_done;

    vecs[0] = '{64'hFEDCBA9876543210, 0,   1'b0, 64'hFEDCBA9876543210, 4'h0};
    vecs[1] = '{64'hFEDCBA9876543210, 100, 1'b0, 64'hFEDCBA9876543210, 4'h0};
    vecs[2] = '{64'hA5A5A5A5A5A5A5A5, 0,   1'b1, 64'hA5A5A5A5A5A5A5A5, 4'h0};
    vecs[3] = '{64'h1200000000000000, 0,   1'b0, 64'h1200000000000000, 4'h3};

    repeat (3) @(negedge clk);
    check("rst_outputs", {sd, sclk, cs_n, busy, done, aborted, in_ready}, 7'b0010000);
`ifdef LUT_LOADER_CKSUM_EN
    check("rst_cksum", cksum, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {sd, sclk, cs_n, busy, done, aborted, in_ready}, 7'b0010000);

    for (int i = 0; i < 4; i++) do_load(vecs[i], i);

    // abort while idle must not touch anything
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort", {aborted, busy, cs_n}, 3'b001);

    // start and abort together in IDLE: start wins; then abort after ~10 bits
    exp_q.delete(); edge_cnt = 0;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_wins", busy, 1);
    b = 0; hold_off = 0; cyc = 0;
    while (edge_cnt < 10 && cyc < 1000) begin
      drive_step(vecs[0].data, b, hold_off, 0);
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_bits", edge_cnt >= 10, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_outputs", {sclk, cs_n, busy, aborted, in_ready, done}, 6'b010100);
    n_done = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_sticky", aborted, 1);
    do_load(vecs[0], 4);

    // asynchronous reset during HI
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    b = 0; hold_off = 0; cyc = 0;
    while (!sclk && cyc < 100) begin
      drive_step(vecs[0].data, b, hold_off, 0);
      @(negedge clk);
      cyc++;
    end
    check("hi_reached", sclk, 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {sd, sclk, cs_n, busy, done, aborted, in_ready}, 7'b0010000);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {sclk, cs_n, busy, in_ready}, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
